// File: rtl/motor_register_bank_pkg.sv
// Shared types and constants for the motor register bank: register map,
// per-motor config/status layouts, reset values and commit FSM states.
package motor_reg_pkg;

    localparam int unsigned STAT_W = 192;
    localparam int unsigned CFG_W  = 176;

    localparam logic [7:0] REG_ID       = 8'h00;
    localparam logic [7:0] REG_KP       = 8'h01;
    localparam logic [7:0] REG_KI       = 8'h02;
    localparam logic [7:0] REG_KD       = 8'h03;
    localparam logic [7:0] REG_ENC0     = 8'h04;
    localparam logic [7:0] REG_ENC1     = 8'h05;
    localparam logic [7:0] REG_PWMLIM   = 8'h08;
    localparam logic [7:0] REG_INTLIM   = 8'h09;
    localparam logic [7:0] REG_DEADBAND = 8'h0A;
    localparam logic [7:0] REG_MODE     = 8'h0B;
    localparam logic [7:0] REG_SP       = 8'h0C;
    localparam logic [7:0] REG_ERROR    = 8'h0D;
    localparam logic [7:0] REG_FREQ     = 8'h11;
    localparam logic [7:0] REG_GEAR     = 8'h12;
    localparam logic [7:0] REG_CRC      = 8'h15;
    localparam logic [7:0] REG_QUALITY  = 8'h16;
    localparam logic [7:0] REG_PWM      = 8'h17;
    localparam logic [7:0] REG_DISP     = 8'h18;
    localparam logic [7:0] REG_COMMIT   = 8'h20;
    localparam logic [7:0] REG_SNAP     = 8'h21;
    localparam logic [7:0] REG_STATE    = 8'h22;
    localparam logic [7:0] ACTIVE_BIT   = 8'h40;

    localparam logic [31:0] UNMAPPED = 32'hDEADBEEF;

    typedef struct packed {
        logic [7:0]  Kp;
        logic [7:0]  Ki;
        logic [7:0]  Kd;
        logic [23:0] sp;
        logic [23:0] PWMLimit;
        logic [23:0] IntegralLimit;
        logic [23:0] deadband;
        logic [23:0] gearboxRatio;
        logic [7:0]  control_mode;
    } motor_cfg_t;

    typedef struct packed {
        logic [31:0] pwm;
        logic [31:0] enc0;
        logic [31:0] enc1;
        logic [31:0] displacement;
        logic [31:0] error;
        logic [15:0] crc;
        logic [15:0] quality;
    } motor_status_t;

    // The config slot on the link side is wider than the fields; upper bits are zero.
    localparam int unsigned CFG_PAD_W = CFG_W - $bits(motor_cfg_t);

    localparam motor_cfg_t CFG_RESET = '{
        Kp: 8'd1, Ki: 8'd0, Kd: 8'd0, sp: 24'd0, PWMLimit: 24'd127,
        IntegralLimit: 24'd50, deadband: 24'd0, gearboxRatio: 24'd53,
        control_mode: 8'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } commit_state_e;

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    function automatic logic [31:0] sext24(input logic [23:0] v);
        return {{8{v[23]}}, v};
    endfunction

    function automatic logic [23:0] clamp_limit(input logic [31:0] v, input logic [23:0] lim);
        if (v[31]) return '0;
        if (v > {8'h00, lim}) return lim;
        return v[23:0];
    endfunction

    // Returns {hit, value} for a config field read; hit=0 when r is not a config field.
    function automatic logic [32:0] cfg_read(input motor_cfg_t c, input logic [7:0] r);
        logic [32:0] res;
        res = {1'b1, 32'h0};
        case (r)
            REG_KP:       res[31:0] = sext8(c.Kp);
            REG_KI:       res[31:0] = sext8(c.Ki);
            REG_KD:       res[31:0] = sext8(c.Kd);
            REG_PWMLIM:   res[31:0] = sext24(c.PWMLimit);
            REG_INTLIM:   res[31:0] = sext24(c.IntegralLimit);
            REG_DEADBAND: res[31:0] = sext24(c.deadband);
            REG_MODE:     res[31:0] = {24'h0, c.control_mode};
            REG_SP:       res[31:0] = sext24(c.sp);
            REG_GEAR:     res[31:0] = sext24(c.gearboxRatio);
            default:      res = {1'b0, UNMAPPED};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/motor_register_bank_if.sv
// Avalon-MM slave bus bundle between the HPS/Qsys fabric and the register bank.
interface motor_register_bank_if;
    logic [15:0] avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/motor_register_bank_commit_fsm.sv
// Commit sequencer: accumulates the pending motor mask and applies it for one
// cycle at the next link frame boundary, then pulses the update outputs.
module motor_commit_fsm
    import motor_reg_pkg::*;
#(
    parameter int unsigned NUM_MOTORS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit_wr_i,
    input  logic [NUM_MOTORS-1:0] commit_data_i,
    input  logic                  frame_boundary_i,
    output commit_state_e         state_o,
    output logic [NUM_MOTORS-1:0] pend_mask_o,
    output logic                  apply_o,
    output logic [NUM_MOTORS-1:0] apply_mask_o,
    output logic                  update_o,
    output logic [NUM_MOTORS-1:0] update_mask_o
);

    commit_state_e         state_q, state_d;
    logic [NUM_MOTORS-1:0] pend_q, pend_d;
    logic                  update_q, update_d;
    logic [NUM_MOTORS-1:0] upd_mask_q, upd_mask_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            update_q   <= 1'b0;
            upd_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            update_q   <= update_d;
            upd_mask_q <= upd_mask_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        update_d   = 1'b0;
        upd_mask_d = upd_mask_q;
        unique case (state_q)
            ST_IDLE: begin
                // A boundary seen in IDLE is never used, even alongside a commit write.
                if (commit_wr_i) begin
                    pend_d = pend_q | commit_data_i;
                    if (pend_d != '0) state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (commit_wr_i) pend_d = pend_q | commit_data_i;
                if (frame_boundary_i) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                update_d   = 1'b1;
                upd_mask_d = pend_q;
                pend_d     = commit_wr_i ? commit_data_i : '0;
                state_d    = (pend_d != '0) ? ST_PENDING : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_o       = state_q;
    assign pend_mask_o   = pend_q;
    assign apply_o       = (state_q == ST_APPLY);
    assign apply_mask_o  = pend_q;
    assign update_o      = update_q;
    assign update_mask_o = upd_mask_q;

endmodule

// File: rtl/motor_register_bank.sv
// Avalon-MM register bank with shadow/active motor config and frame-coherent status snapshot.
// Optional build macro MOTOR_REG_LIMIT_CLAMP_EN saturates PWMLimit/IntegralLimit writes.
module motor_register_bank
    import motor_reg_pkg::*;
#(
    parameter int unsigned NUM_MOTORS = 8,
    parameter logic [31:0] ID_WORD    = 32'hB15B0002,
    parameter logic [23:0] LIMIT_MAX  = 24'd1023,
    parameter int unsigned FREQ_RESET = 100
) (
    input  logic                         clk,
    input  logic                         reset,
    motor_register_bank_if.slave         avs,
    input  logic                         frame_boundary,
    input  logic                         status_valid,
    input  logic [NUM_MOTORS*STAT_W-1:0] status_in,
    output logic [NUM_MOTORS*CFG_W-1:0]  cfg_active,
    output logic                         cfg_update,
    output logic [NUM_MOTORS-1:0]        cfg_update_mask,
    output logic [31:0]                  update_frequency_Hz
);

`ifdef MOTOR_REG_LIMIT_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    logic [7:0]  reg_addr;
    logic [7:0]  mot_idx;
    logic [31:0] wdata;
    logic        motor_hit;
    logic        commit_wr;
    logic        snap_wr;

    motor_cfg_t    shadow_q [NUM_MOTORS];
    motor_cfg_t    active_q [NUM_MOTORS];
    motor_status_t snap_q   [NUM_MOTORS];
    motor_status_t status_vec [NUM_MOTORS];
    motor_cfg_t    shadow_sel, active_sel;
    motor_status_t snap_sel;
    motor_cfg_t    shadow_wr_d;
    logic          shadow_wr_en;
    logic [23:0]   limit_wdata;

    logic [31:0] freq_q;
    logic        armed_q;
    logic [15:0] snap_count_q;
    logic        rd_pend_q;
    logic [31:0] readdata_q, rd_d;
    logic [32:0] cfg_rd;

    commit_state_e         fsm_state;
    logic [NUM_MOTORS-1:0] pend_mask;
    logic                  apply;
    logic [NUM_MOTORS-1:0] apply_mask;

    assign reg_addr  = avs.avs_address[15:8];
    assign mot_idx   = avs.avs_address[7:0];
    assign wdata     = avs.avs_writedata;
    assign motor_hit = ({24'h0, mot_idx} < NUM_MOTORS);
    assign commit_wr = avs.avs_write && (reg_addr == REG_COMMIT);
    assign snap_wr   = avs.avs_write && (reg_addr == REG_SNAP);

    motor_commit_fsm #(.NUM_MOTORS(NUM_MOTORS)) u_commit (
        .clk              (clk),
        .reset            (reset),
        .commit_wr_i      (commit_wr),
        .commit_data_i    (wdata[NUM_MOTORS-1:0]),
        .frame_boundary_i (frame_boundary),
        .state_o          (fsm_state),
        .pend_mask_o      (pend_mask),
        .apply_o          (apply),
        .apply_mask_o     (apply_mask),
        .update_o         (cfg_update),
        .update_mask_o    (cfg_update_mask)
    );

    always_comb begin
        shadow_sel = CFG_RESET;
        active_sel = CFG_RESET;
        snap_sel   = '0;
        for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
            status_vec[m] = motor_status_t'(status_in[m*STAT_W +: STAT_W]);
            if ({24'h0, mot_idx} == m) begin
                shadow_sel = shadow_q[m];
                active_sel = active_q[m];
                snap_sel   = snap_q[m];
            end
        end
    end

    always_comb begin
        limit_wdata  = CLAMP_EN ? clamp_limit(wdata, LIMIT_MAX) : wdata[23:0];
        shadow_wr_d  = shadow_sel;
        shadow_wr_en = 1'b0;
        if (avs.avs_write && motor_hit) begin
            shadow_wr_en = 1'b1;
            case (reg_addr)
                REG_KP:       shadow_wr_d.Kp            = wdata[7:0];
                REG_KI:       shadow_wr_d.Ki            = wdata[7:0];
                REG_KD:       shadow_wr_d.Kd            = wdata[7:0];
                REG_PWMLIM:   shadow_wr_d.PWMLimit      = limit_wdata;
                REG_INTLIM:   shadow_wr_d.IntegralLimit = limit_wdata;
                REG_DEADBAND: shadow_wr_d.deadband      = wdata[23:0];
                REG_MODE:     shadow_wr_d.control_mode  = wdata[7:0];
                REG_SP:       shadow_wr_d.sp            = wdata[23:0];
                REG_GEAR:     shadow_wr_d.gearboxRatio  = wdata[23:0];
                default:      shadow_wr_en = 1'b0;
            endcase
        end
    end

    // Active copy samples the shadow before any same-cycle host write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
                shadow_q[m] <= CFG_RESET;
                active_q[m] <= CFG_RESET;
            end
        end else begin
            for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
                if (apply && apply_mask[m]) active_q[m] <= shadow_q[m];
                if (shadow_wr_en && ({24'h0, mot_idx} == m)) shadow_q[m] <= shadow_wr_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_q <= FREQ_RESET;
        end else if (avs.avs_write && (reg_addr == REG_FREQ)) begin
            freq_q <= wdata;
        end
    end

    // Arming wins over a coincident status_valid so the capture is always from a later frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q      <= 1'b0;
            snap_count_q <= '0;
            for (int unsigned m = 0; m < NUM_MOTORS; m++) snap_q[m] <= '0;
        end else if (snap_wr) begin
            armed_q <= 1'b1;
        end else if (status_valid && armed_q) begin
            armed_q      <= 1'b0;
            snap_count_q <= snap_count_q + 16'd1;
            for (int unsigned m = 0; m < NUM_MOTORS; m++) snap_q[m] <= status_vec[m];
        end
    end

    always_comb begin
        rd_d   = UNMAPPED;
        cfg_rd = cfg_read(reg_addr[6] ? active_sel : shadow_sel, reg_addr & ~ACTIVE_BIT);
        case (reg_addr)
            REG_ID:      rd_d = ID_WORD;
            REG_FREQ:    rd_d = freq_q;
            REG_COMMIT:  rd_d = 32'(pend_mask);
            REG_SNAP:    rd_d = {armed_q, 15'h0, snap_count_q};
            REG_STATE:   rd_d = {30'h0, fsm_state};
            REG_ENC0:    if (motor_hit) rd_d = snap_sel.enc0;
            REG_ENC1:    if (motor_hit) rd_d = snap_sel.enc1;
            REG_ERROR:   if (motor_hit) rd_d = snap_sel.error;
            REG_CRC:     if (motor_hit) rd_d = {16'h0, snap_sel.crc};
            REG_QUALITY: if (motor_hit) rd_d = {16'h0, snap_sel.quality};
            REG_PWM:     if (motor_hit) rd_d = snap_sel.pwm;
            REG_DISP:    if (motor_hit) rd_d = snap_sel.displacement;
            default:     if (motor_hit && cfg_rd[32]) rd_d = cfg_rd[31:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            rd_pend_q <= avs.avs_read && !rd_pend_q;
            if (avs.avs_read && !rd_pend_q) readdata_q <= rd_d;
        end
    end

    assign avs.avs_readdata    = readdata_q;
    assign avs.avs_waitrequest = avs.avs_read && !rd_pend_q;
    assign update_frequency_Hz = freq_q;

    always_comb begin
        cfg_active = '0;
        for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
            cfg_active[m*CFG_W +: CFG_W] = {{CFG_PAD_W{1'b0}}, active_q[m]};
        end
    end

endmodule

// File: tb/tb_motor_register_bank.sv
// Directed self-checking bench for motor_register_bank: register map, commit
// timing at frame boundaries, snapshot coherence and limit write behaviour.
module tb_motor_register_bank;
    import motor_reg_pkg::*;

    localparam int unsigned NM = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    motor_register_bank_if bus();
    logic                 frame_boundary;
    logic                 status_valid;
    logic [NM*STAT_W-1:0] status_in;
    logic [NM*CFG_W-1:0]  cfg_active;
    logic                 cfg_update;
    logic [NM-1:0]        cfg_update_mask;
    logic [31:0]          update_frequency_Hz;

    motor_status_t st [NM];
    int            checks = 0;
    int            failures = 0;
    int            upd_pulses = 0;
    logic [NM-1:0] last_upd_mask = '0;
    logic [31:0]   exp_big, exp_neg, rdata;
    int unsigned   stall;
    motor_cfg_t    c;

    motor_register_bank #(
        .NUM_MOTORS (NM),
        .ID_WORD    (32'hB15B0002),
        .LIMIT_MAX  (24'd1023),
        .FREQ_RESET (100)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .avs                 (bus),
        .frame_boundary      (frame_boundary),
        .status_valid        (status_valid),
        .status_in           (status_in),
        .cfg_active          (cfg_active),
        .cfg_update          (cfg_update),
        .cfg_update_mask     (cfg_update_mask),
        .update_frequency_Hz (update_frequency_Hz)
    );

    always_comb begin
        status_in = '0;
        for (int i = 0; i < NM; i++) status_in[i*STAT_W +: STAT_W] = st[i];
    end

    always @(negedge clk) begin
        if (!reset && cfg_update) begin
            upd_pulses++;
            last_upd_mask = cfg_update_mask;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic motor_cfg_t get_cfg(input int m);
        return cfg_active[m*CFG_W +: $bits(motor_cfg_t)];
    endfunction

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        @(posedge clk); #1;
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data, output int unsigned stall_n);
        int unsigned n;
        @(posedge clk); #1;
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        stall_n = 0;
        n = 0;
        #1;
        while (bus.avs_waitrequest && n < 8) begin
            stall_n++;
            n++;
            @(posedge clk); #1;
        end
        if (n >= 8) check_eq("rd_timeout", n, 32'd0);
        data = bus.avs_readdata;
        bus.avs_read = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int unsigned s;
        bus_read(addr, d, s);
        check_eq(tag, d, exp);
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1; frame_boundary = 1'b1;
        @(posedge clk); #1; frame_boundary = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_status();
        @(posedge clk); #1; status_valid = 1'b1;
        @(posedge clk); #1; status_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MOTOR_REG_LIMIT_CLAMP_EN
        exp_big = 32'd1023;
        exp_neg = 32'd0;
`else
        exp_big = 32'd5000;
        exp_neg = 32'hFFFFFFFD;
`endif
        for (int i = 0; i < NM; i++) st[i] = '0;
        reset = 1'b1;
        frame_boundary = 1'b0;
        status_valid = 1'b0;
        bus.avs_address = '0;
        bus.avs_write = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        check_eq("rst_readdata", bus.avs_readdata, 32'h0);
        check_eq("rst_waitreq", {31'h0, bus.avs_waitrequest}, 32'h0);
        check_eq("rst_update", {31'h0, cfg_update}, 32'h0);
        check_eq("rst_freq", update_frequency_Hz, 32'd100);
        c = get_cfg(7);
        check_eq("rst_act_pwmlim7", {8'h0, c.PWMLimit}, 32'd127);
        check_eq("rst_act_gear7", {8'h0, c.gearboxRatio}, 32'd53);

        bus_read(16'h0000, rdata, stall);
        check_eq("id", rdata, 32'hB15B0002);
        check_eq("id_stall", stall, 32'd1);
        bus_read(16'h0801, rdata, stall);
        check_eq("pwmlim1", rdata, 32'd127);
        check_eq("pwmlim1_stall", stall, 32'd1);

        // shadow write leaves active alone
        bus_write(16'h0103, 32'd5);
        rd_check("kp3_shadow", 16'h0103, 32'd5);
        rd_check("kp3_active_pre", 16'h4103, 32'd1);
        check_eq("no_update_yet", upd_pulses, 32'd0);

        // commit motor 3 at one boundary
        bus_write(16'h2000, 32'h08);
        rd_check("pend_mask", 16'h2000, 32'h08);
        rd_check("state_pending", 16'h2200, 32'd1);
        pulse_frame();
        check_eq("upd_count1", upd_pulses, 32'd1);
        check_eq("upd_mask1", {24'h0, last_upd_mask}, 32'h08);
        check_eq("upd_mask_held", {24'h0, cfg_update_mask}, 32'h08);
        rd_check("kp3_active", 16'h4103, 32'd5);
        rd_check("kp2_active", 16'h4102, 32'd1);
        c = get_cfg(3);
        check_eq("cfg_active_kp3", {24'h0, c.Kp}, 32'd5);
        rd_check("state_idle", 16'h2200, 32'd0);

        // commit write coincident with a boundary waits for the next one
        bus_write(16'h0100, 32'hFE);
        @(posedge clk); #1;
        bus.avs_address = 16'h2000; bus.avs_writedata = 32'h01; bus.avs_write = 1'b1;
        frame_boundary = 1'b1;
        @(posedge clk); #1;
        bus.avs_write = 1'b0; frame_boundary = 1'b0;
        repeat (10) @(posedge clk);
        check_eq("same_cycle_no_apply", upd_pulses, 32'd1);
        rd_check("same_cycle_state", 16'h2200, 32'd1);
        rd_check("kp0_active_pre", 16'h4100, 32'd1);
        pulse_frame();
        check_eq("upd_count2", upd_pulses, 32'd2);
        check_eq("upd_mask2", {24'h0, last_upd_mask}, 32'h01);
        rd_check("kp0_active_sext", 16'h4100, 32'hFFFFFFFE);

        // unmapped / out of range / ignored writes
        rd_check("oor_motor", 16'h0108, 32'hDEADBEEF);
        rd_check("unmapped_reg", 16'h0600, 32'hDEADBEEF);
        rd_check("active_freq_unmapped", 16'h5100, 32'hDEADBEEF);
        bus_write(16'h4103, 32'd99);
        rd_check("active_write_ignored", 16'h4103, 32'd5);
        bus_write(16'h1100, 32'd250);
        check_eq("freq_immediate", update_frequency_Hz, 32'd250);
        rd_check("freq_read", 16'h1100, 32'd250);

        // limit fields
        bus_write(16'h0801, 32'd5000);
        rd_check("pwmlim_big", 16'h0801, exp_big);
        bus_write(16'h0801, 32'hFFFFFFFD);
        rd_check("pwmlim_neg", 16'h0801, exp_neg);
        bus_write(16'h0901, 32'd5000);
        rd_check("intlim_big", 16'h0901, exp_big);

        // shadow write during APPLY: active takes the pre-write value
        bus_write(16'h0302, 32'd7);
        bus_write(16'h2000, 32'h06);
        @(posedge clk); #1; frame_boundary = 1'b1;
        @(posedge clk); #1; frame_boundary = 1'b0;
        bus.avs_address = 16'h0302; bus.avs_writedata = 32'd9; bus.avs_write = 1'b1;
        @(posedge clk); #1; bus.avs_write = 1'b0;
        repeat (2) @(posedge clk);
        check_eq("upd_mask3", {24'h0, last_upd_mask}, 32'h06);
        rd_check("kd2_active_prewrite", 16'h4302, 32'd7);
        rd_check("kd2_shadow", 16'h0302, 32'd9);
        rd_check("pwmlim1_active", 16'h4801, exp_neg);

        // commit write during APPLY returns to PENDING with a fresh mask
        bus_write(16'h2000, 32'h04);
        @(posedge clk); #1; frame_boundary = 1'b1;
        @(posedge clk); #1; frame_boundary = 1'b0;
        bus.avs_address = 16'h2000; bus.avs_writedata = 32'h01; bus.avs_write = 1'b1;
        @(posedge clk); #1; bus.avs_write = 1'b0;
        repeat (2) @(posedge clk);
        check_eq("upd_mask4", {24'h0, last_upd_mask}, 32'h04);
        rd_check("kd2_active", 16'h4302, 32'd9);
        rd_check("fresh_pend_mask", 16'h2000, 32'h01);
        rd_check("apply_to_pending", 16'h2200, 32'd1);

        // snapshot
        st[2].enc0 = 32'hFFFFFFF9;
        st[2].crc  = 16'hBEEF;
        bus_write(16'h2100, 32'h0);
        rd_check("snap_armed", 16'h2100, 32'h80000000);
        pulse_status();
        rd_check("snap_enc0", 16'h0402, 32'hFFFFFFF9);
        rd_check("snap_crc", 16'h1502, 32'h0000BEEF);
        rd_check("snap_count1", 16'h2100, 32'h00000001);
        st[2].enc0 = 32'd1234;
        pulse_status();
        rd_check("snap_unarmed_hold", 16'h0402, 32'hFFFFFFF9);
        rd_check("snap_count_hold", 16'h2100, 32'h00000001);
        st[2].enc0 = 32'd55;
        @(posedge clk); #1;
        bus.avs_address = 16'h2100; bus.avs_write = 1'b1; status_valid = 1'b1;
        @(posedge clk); #1;
        bus.avs_write = 1'b0; status_valid = 1'b0;
        rd_check("arm_same_cycle", 16'h2100, 32'h80000001);
        rd_check("arm_same_cycle_enc0", 16'h0402, 32'hFFFFFFF9);
        pulse_status();
        rd_check("snap_enc0_2", 16'h0402, 32'd55);
        rd_check("snap_count2", 16'h2100, 32'h00000002);
        rd_check("snap_oor", 16'h0408, 32'hDEADBEEF);

        // reset mid-operation (commit pending and snapshot armed)
        bus_write(16'h2100, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        #20 reset = 1'b0;
        check_eq("rst2_freq", update_frequency_Hz, 32'd100);
        check_eq("rst2_upd_mask", {24'h0, cfg_update_mask}, 32'h0);
        rd_check("rst2_pend", 16'h2000, 32'h0);
        rd_check("rst2_state", 16'h2200, 32'h0);
        rd_check("rst2_snap", 16'h2100, 32'h0);
        rd_check("rst2_kd2_active", 16'h4302, 32'h0);
        rd_check("rst2_kp3_active", 16'h4103, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
